mem_data_ram: RTL and testbench

Parametrised, clocked successor to the MEM-stage data memory of the MIPS pipeline. Byte-addressed, big-endian RAM with a valid/ready request port and a registered response port. Supports LB/LBU/LH/LHU/LW and SB/SH/SW, configurable wait states, and misaligned/out-of-range error detection. The MEM stage holds its request and stalls upstream while `req_ready` is low.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 63 ++++++
 rtl/mem_data_ram.sv | 152 +++++++++++++++
 tb/tb_mem_data_ram.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data RAM: size encodings, FSM states and the latched request.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian byte-lane steering: store enables/lanes and load extraction with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Offset 0 is the most significant byte of the word.
  always_comb begin
    be    = 4'b0000;
    wlane = 32'h0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b1000 >> off;
        wlane = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be    = off[1] ? 4'b0011 : 4'b1100;
        wlane = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wlane = wdata;
      end
      default: begin
        be    = 4'b0000;
        wlane = 32'h0;
      end
    endcase
  end

  always_comb begin
    rbyte = 8'h0;
    case (off)
      2'd0:    rbyte = rword[31:24];
      2'd1:    rbyte = rword[23:16];
      2'd2:    rbyte = rword[15:8];
      default: rbyte = rword[7:0];
    endcase
    rhalf = off[1] ? rword[15:0] : rword[31:16];
  end

  always_comb begin
    rdata = 32'h0;
    case (size)
      SZ_BYTE: rdata = sgn ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      SZ_HALF: rdata = sgn ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
      SZ_WORD: rdata = rword;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_data_ram.sv
// Clocked big-endian data RAM with valid/ready requests, wait states and error detection.
// Optional statistics counters are built when DMEM_STATS_EN is defined.
module mem_data_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errors,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the requester holds its inputs until then; the response is a single rsp_valid pulse.

  localparam int WORDS      = 2 ** (ADDR_W - 2);
  localparam int CNT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [2:0] CNT_INIT = 3'(CNT_INIT_I);

  state_t              state;
  dmem_req_t           req_q;
  dmem_req_t           req_in;
  dmem_req_t           cur;
  logic [2:0]          cnt;
  logic                accept;
  logic                commit;
  logic                err;
  logic [ADDR_W-3:0]   widx;
  logic [31:0]         rword;
  logic [3:0]          be;
  logic [31:0]         wlane;
  logic [31:0]         ld_data;
  logic [31:0]         mem [WORDS];

  assign req_ready = rst_n && (state == ST_IDLE);
  assign dbg_state = state;
  assign accept    = req_valid && req_ready;
  assign req_in    = '{write: req_write, size: req_size, sgn: req_signed,
                       addr: req_addr, wdata: req_wdata};

  // With zero wait states the access commits on the accept edge, straight from the ports.
  assign cur    = (state == ST_IDLE) ? req_in : req_q;
  assign commit = (accept && (WAIT_CYCLES == 0)) || ((state == ST_WAIT) && (cnt == 3'd0));

  assign err = (cur.size == 2'b11)
            || ((cur.size == SZ_HALF) && cur.addr[0])
            || ((cur.size == SZ_WORD) && (cur.addr[1:0] != 2'b00))
            || (|cur.addr[31:ADDR_W]);

  assign widx  = cur.addr[ADDR_W-1:2];
  assign rword = mem[widx];

  dmem_lane_align u_lane (
    .size  (cur.size),
    .off   (cur.addr[1:0]),
    .sgn   (cur.sgn),
    .wdata (cur.wdata),
    .rword (rword),
    .be    (be),
    .wlane (wlane),
    .rdata (ld_data)
  );

  // Memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && cur.write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      cnt       <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q <= req_in;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd0) state <= ST_RESP;
          else             cnt   <= cnt - 3'd1;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        default: state <= ST_IDLE;
      endcase
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_error <= err;
        rsp_rdata <= (err || cur.write) ? 32'h0 : ld_data;
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] loads_q, stores_q, errors_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loads_q  <= 32'h0;
      stores_q <= 32'h0;
      errors_q <= 32'h0;
    end else if (commit) begin
      if (err)            errors_q <= errors_q + 32'h1;
      else if (cur.write) stores_q <= stores_q + 32'h1;
      else                loads_q  <= loads_q + 32'h1;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errors = errors_q;
`else
  assign stat_loads  = 32'h0;
  assign stat_stores = 32'h0;
  assign stat_errors = 32'h0;
`endif

endmodule

// File: tb/tb_mem_data_ram.sv
// Directed self-checking bench for mem_data_ram (ADDR_W=12, WAIT_CYCLES=1).
module tb_mem_data_ram;

  localparam int ADDR_W      = 12;
  localparam int WAIT_CYCLES = 1;
  localparam int EXP_LAT     = WAIT_CYCLES + 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] stat_loads;
  logic [31:0] stat_stores;
  logic [31:0] stat_errors;
  logic [1:0]  dbg_state;

  int passed;
  int total;

  mem_data_ram #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errors (stat_errors),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one request, scramble inputs after accept, wait for the response.
  task automatic do_access(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_size   = ~sz;
    req_signed = ~sg;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = ~wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    rd = rsp_rdata;
    er = rsp_error;
    if (!rsp_valid) lat = 99;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready_low got %b exp 0", req_ready);
    else passed++;
    total++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready_high got %b exp 1", req_ready);
    else passed++;
    total++;
    if ({rsp_valid, rsp_error, rsp_rdata} !== 34'h0)
      $display("FAIL reset_rsp got v=%b e=%b d=%h exp all 0", rsp_valid, rsp_error, rsp_rdata);
    else passed++;
    total++;
    if ({stat_loads, stat_stores, stat_errors} !== 96'h0)
      $display("FAIL reset_stats got %h/%h/%h exp 0/0/0", stat_loads, stat_stores, stat_errors);
    else passed++;
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    total++;
    if (lat != EXP_LAT || er !== 1'b0 || rd !== 32'h0)
      $display("FAIL sw_10 got lat=%0d e=%b d=%h exp lat=%0d e=0 d=0", lat, er, rd, EXP_LAT);
    else passed++;
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (lat != EXP_LAT || er !== 1'b0 || rd !== 32'hDEAD_BEEF)
      $display("FAIL lw_10 got lat=%0d e=%b d=%h exp lat=%0d e=0 d=deadbeef", lat, er, rd, EXP_LAT);
    else passed++;
  endtask

  task automatic test_subword_loads();
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'hFFFF_FFDE) $display("FAIL lb_10 got e=%b d=%h exp e=0 d=ffffffde", er, rd);
    else passed++;
    do_access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'h0000_00AD) $display("FAIL lbu_11 got e=%b d=%h exp e=0 d=000000ad", er, rd);
    else passed++;
    do_access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'hFFFF_BEEF) $display("FAIL lh_12 got e=%b d=%h exp e=0 d=ffffbeef", er, rd);
    else passed++;
    do_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'h0000_BEEF) $display("FAIL lhu_12 got e=%b d=%h exp e=0 d=0000beef", er, rd);
    else passed++;
  endtask

  task automatic test_byte_store();
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF12, rd, er, lat);
    total++;
    if (er !== 1'b0) $display("FAIL sb_13 got e=%b exp 0", er);
    else passed++;
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hDEAD_BE12) $display("FAIL lw_after_sb got %h exp deadbe12", rd);
    else passed++;
    do_access(1'b1, 2'b01, 1'b0, 32'hFFE, 32'h0000_5A3C, rd, er, lat);
    do_access(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd[15:0] !== 16'h5A3C)
      $display("FAIL top_word_half got e=%b d=%h exp e=0 low=5a3c", er, rd);
    else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(1'b1, 2'b10, 1'b0, 32'h0, 32'h0123_4567, rd, er, lat);
    do_access(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != EXP_LAT)
      $display("FAIL err_lw_02 got e=%b d=%h lat=%0d exp e=1 d=0 lat=%0d", er, rd, lat, EXP_LAT);
    else passed++;
    do_access(1'b1, 2'b01, 1'b0, 32'h1, 32'h0000_AAAA, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_sh_01 got e=%b d=%h exp e=1 d=0", er, rd);
    else passed++;
    do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'h0123_4567) $display("FAIL lw_00_after_sh got e=%b d=%h exp e=0 d=01234567", er, rd);
    else passed++;
    do_access(1'b0, 2'b10, 1'b0, 32'h1 << ADDR_W, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_range got e=%b d=%h exp e=1 d=0", er, rd);
    else passed++;
    do_access(1'b0, 2'b00, 1'b0, 32'h8000_0010, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_range_msb got e=%b d=%h exp e=1 d=0", er, rd);
    else passed++;
    do_access(1'b1, 2'b11, 1'b0, 32'h10, 32'h7777_7777, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_size11 got e=%b d=%h exp e=1 d=0", er, rd);
    else passed++;
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hDEAD_BE12) $display("FAIL lw_after_size11 got %h exp deadbe12", rd);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int ready_cnt;
    int rsp_cnt;
    int first_gap;
    int last_ready;
    ready_cnt  = 0;
    rsp_cnt    = 0;
    first_gap  = 0;
    last_ready = -1;
    req_write  = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_valid  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) begin
        ready_cnt++;
        if (last_ready >= 0 && first_gap == 0) first_gap = i - last_ready;
        last_ready = i;
      end
      if (rsp_valid) rsp_cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    total++;
    if (ready_cnt != 4 || first_gap != WAIT_CYCLES + 2)
      $display("FAIL b2b_ready got pulses=%0d gap=%0d exp pulses=4 gap=%0d", ready_cnt, first_gap, WAIT_CYCLES + 2);
    else passed++;
    total++;
    if (rsp_cnt != 4) $display("FAIL b2b_rsp got %0d exp 4", rsp_cnt);
    else passed++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_during_wait();
    logic [31:0] rd;
    logic er;
    int lat;
    int rsp_seen;
    rsp_seen   = 0;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_wdata  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL rst_wait_outputs got ready=%b v=%b exp 0/0", req_ready, rsp_valid);
    else passed++;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    total++;
    if (rsp_seen != 0) $display("FAIL rst_wait_no_rsp got %0d pulses exp 0", rsp_seen);
    else passed++;
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hDEAD_BE12) $display("FAIL rst_wait_mem got %h exp deadbe12", rd);
    else passed++;
  endtask

  task automatic test_stats();
    logic [31:0] rd;
    logic er;
    int lat;
    logic [31:0] exp_l, exp_s, exp_e;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_2222, rd, er, lat);
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    do_access(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0033, rd, er, lat);
    do_access(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, er, lat);
    do_access(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, rd, er, lat);
    do_access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat);
`ifdef DMEM_STATS_EN
    exp_l = 32'd3;
    exp_s = 32'd2;
    exp_e = 32'd1;
`else
    exp_l = 32'd0;
    exp_s = 32'd0;
    exp_e = 32'd0;
`endif
    total++;
    if (stat_loads !== exp_l || stat_stores !== exp_s || stat_errors !== exp_e)
      $display("FAIL stats got %0d/%0d/%0d exp %0d/%0d/%0d",
               stat_loads, stat_stores, stat_errors, exp_l, exp_s, exp_e);
    else passed++;
    total++;
    if (rd !== 32'h0000_2222) $display("FAIL stats_lhu_22 got %h exp 00002222", rd);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_store_load();
    test_subword_loads();
    test_byte_store();
    test_errors();
    test_back_to_back();
    test_reset_during_wait();
    test_stats();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
